// File: rtl/debug_pkg.sv
// Shared types and constants for the debug-module abstract command logic.
package debug_pkg;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        AC_IDLE,
        AC_ISSUE,
        AC_WAIT,
        AC_DONE
    } ac_state_e;

    localparam logic [15:0] REGNO_CSR_HI = 16'h0FFF;
    localparam logic [15:0] REGNO_GPR_LO = 16'h1000;
    localparam logic [15:0] REGNO_GPR_HI = 16'h101F;
    localparam logic [15:0] REGNO_DCSR   = 16'h07B0;
    localparam logic [15:0] REGNO_DPC    = 16'h07B1;

    localparam int CMD_TYPE_LSB     = 24;
    localparam int CMD_SIZE_LSB     = 20;
    localparam int CMD_POSTEXEC_BIT = 18;
    localparam int CMD_TRANSFER_BIT = 17;
    localparam int CMD_WRITE_BIT    = 16;

    localparam logic [2:0] AARSIZE_32 = 3'd2;

    // CSRs and GPRs form one contiguous window 0x0000..0x101F.
    function automatic logic regno_ok(input logic [15:0] regno);
        return (regno <= REGNO_CSR_HI) ||
               ((regno >= REGNO_GPR_LO) && (regno <= REGNO_GPR_HI));
    endfunction

endpackage

// File: rtl/dm_ac_decode.sv
// Combinational acceptance check of an access-register command word.
module dm_ac_decode
    import debug_pkg::*;
(
    input  logic [31:0] cmd_i,
    input  logic        halted_i,
    output logic        accept_o,
    output logic [2:0]  err_code_o
);

    logic [7:0]  cmdtype;
    logic [2:0]  aarsize;
    logic        postexec;
    logic        transfer;
    logic [15:0] regno;
    logic        notsup;
    logic        unused_bits;

    assign cmdtype     = cmd_i[CMD_TYPE_LSB +: 8];
    assign aarsize     = cmd_i[CMD_SIZE_LSB +: 3];
    assign postexec    = cmd_i[CMD_POSTEXEC_BIT];
    assign transfer    = cmd_i[CMD_TRANSFER_BIT];
    assign regno       = cmd_i[15:0];
    assign unused_bits = ^{cmd_i[23], cmd_i[19], cmd_i[CMD_WRITE_BIT]};

    assign notsup = (cmdtype != 8'd0) || (aarsize != AARSIZE_32) || postexec ||
                    (transfer && !regno_ok(regno));

    always_comb begin
        accept_o   = 1'b0;
        err_code_o = CMDERR_NONE;
        if (notsup)         err_code_o = CMDERR_NOTSUP;
        else if (!halted_i) err_code_o = CMDERR_HALTRESUME;
        else                accept_o   = 1'b1;
    end

endmodule

// File: rtl/dm_abstract_cmd_ctrl.sv
// Abstract-command sequencer: drives dbg_ar_*, owns data0/busy/cmderr.
// Optional DM_AUTOEXEC_EN adds autoexecdata[0] re-issue of the last accepted command.
module dm_abstract_cmd_ctrl
    import debug_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_i,
    input  logic        data0_we_i,
    input  logic        data0_re_i,
    input  logic [31:0] data0_i,
    output logic [31:0] data0_o,
    input  logic        abscs_we_i,
    input  logic [2:0]  cmderr_clr_i,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    input  logic        core_halted_i,
    output logic        dbg_ar_en,
    output logic        dbg_ar_wr,
    output logic [15:0] dbg_ar_ad,
    output logic [31:0] dbg_ar_do,
    input  logic [31:0] dbg_ar_di,
    input  logic        dbg_ar_err_i
`ifdef DM_AUTOEXEC_EN
    ,
    input  logic        autoexec_we_i,
    input  logic        autoexec_i
`endif
);

    ac_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] data0_q, data0_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [15:0] regno_q, regno_d;
    logic        write_q, write_d;
    logic        busy;
    logic        launch;
    logic [31:0] dec_cmd;
    logic        dec_accept;
    logic [2:0]  dec_err;
`ifdef DM_AUTOEXEC_EN
    logic        autoexec_q, autoexec_d;
    logic [31:0] stored_q, stored_d;
    logic        stored_vld_q, stored_vld_d;
`endif

    assign busy = (state_q != AC_IDLE);

    // Command source: a DMI write wins over an autoexec trigger in the same cycle.
    always_comb begin
        dec_cmd = cmd_i;
        launch  = cmd_we_i;
`ifdef DM_AUTOEXEC_EN
        if (!cmd_we_i && (data0_we_i || data0_re_i) && autoexec_q && stored_vld_q) begin
            dec_cmd = stored_q;
            launch  = 1'b1;
        end
`endif
    end

    dm_ac_decode u_decode (
        .cmd_i      (dec_cmd),
        .halted_i   (core_halted_i),
        .accept_o   (dec_accept),
        .err_code_o (dec_err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data0_d  = data0_q;
        cmderr_d = cmderr_q;
        regno_d  = regno_q;
        write_d  = write_q;
`ifdef DM_AUTOEXEC_EN
        autoexec_d   = autoexec_we_i ? autoexec_i : autoexec_q;
        stored_d     = stored_q;
        stored_vld_d = stored_vld_q;
`endif
        // Clear first so that any error set below in the same cycle wins.
        if (abscs_we_i) cmderr_d = cmderr_q & ~cmderr_clr_i;
        if (busy && (cmd_we_i || data0_we_i || data0_re_i) && (cmderr_q == CMDERR_NONE))
            cmderr_d = CMDERR_BUSY;

        case (state_q)
            AC_IDLE: begin
                if (data0_we_i) data0_d = data0_i;
                if (launch && (cmderr_q == CMDERR_NONE)) begin
                    if (dec_accept) begin
                        regno_d = dec_cmd[15:0];
                        write_d = dec_cmd[CMD_WRITE_BIT];
                        state_d = dec_cmd[CMD_TRANSFER_BIT] ? AC_ISSUE : AC_DONE;
`ifdef DM_AUTOEXEC_EN
                        stored_d     = dec_cmd;
                        stored_vld_d = 1'b1;
`endif
                    end else begin
                        cmderr_d = dec_err;
                    end
                end
            end
            AC_ISSUE: begin
                cnt_d = 2'd0;
                if (!core_halted_i) begin
                    cmderr_d = CMDERR_HALTRESUME;
                    state_d  = AC_DONE;
                end else if (dbg_ar_err_i) begin
                    cmderr_d = CMDERR_EXCEPT;
                    state_d  = AC_DONE;
                end else begin
                    state_d = write_q ? AC_DONE : AC_WAIT;
                end
            end
            AC_WAIT: begin
                if (!core_halted_i) begin
                    cmderr_d = CMDERR_HALTRESUME;
                    state_d  = AC_DONE;
                end else if (cnt_q == 2'(READ_LAT - 1)) begin
                    data0_d = dbg_ar_di;
                    state_d = AC_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = AC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= AC_IDLE;
            cnt_q    <= 2'd0;
            data0_q  <= 32'd0;
            cmderr_q <= 3'd0;
            regno_q  <= 16'd0;
            write_q  <= 1'b0;
`ifdef DM_AUTOEXEC_EN
            autoexec_q   <= 1'b0;
            stored_q     <= 32'd0;
            stored_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data0_q  <= data0_d;
            cmderr_q <= cmderr_d;
            regno_q  <= regno_d;
            write_q  <= write_d;
`ifdef DM_AUTOEXEC_EN
            autoexec_q   <= autoexec_d;
            stored_q     <= stored_d;
            stored_vld_q <= stored_vld_d;
`endif
        end
    end

    assign busy_o    = busy;
    assign cmderr_o  = cmderr_q;
    assign data0_o   = data0_q;
    assign dbg_ar_en = (state_q == AC_ISSUE);
    assign dbg_ar_wr = dbg_ar_en & write_q;
    assign dbg_ar_ad = dbg_ar_en ? regno_q : 16'd0;
    assign dbg_ar_do = dbg_ar_en ? data0_q : 32'd0;

endmodule

// File: tb/tb_dm_abstract_cmd_ctrl.sv
// Directed bench for dm_abstract_cmd_ctrl with READ_LAT = 2 and a small core model.
module tb_dm_abstract_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_i = 32'd0;
    logic        data0_we_i = 1'b0;
    logic        data0_re_i = 1'b0;
    logic [31:0] data0_i = 32'd0;
    logic [31:0] data0_o;
    logic        abscs_we_i = 1'b0;
    logic [2:0]  cmderr_clr_i = 3'd0;
    logic        busy_o;
    logic [2:0]  cmderr_o;
    logic        core_halted_i = 1'b1;
    logic        dbg_ar_en, dbg_ar_wr;
    logic [15:0] dbg_ar_ad;
    logic [31:0] dbg_ar_do, dbg_ar_di;
    logic        dbg_ar_err_i;
`ifdef DM_AUTOEXEC_EN
    logic        autoexec_we_i = 1'b0;
    logic        autoexec_i = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    int n0;
    logic        err_inject = 1'b0;
    logic [31:0] core_val = 32'd0;
    logic [1:0]  rdv = 2'b00;

    always #5 clk = ~clk;

    // Core model: read data appears exactly READ_LAT (=2) cycles after the strobe.
    assign dbg_ar_di    = rdv[1] ? core_val : 32'hBADBAD00;
    assign dbg_ar_err_i = err_inject & dbg_ar_en;
    always @(posedge clk) begin
        rdv <= {rdv[0], dbg_ar_en & ~dbg_ar_wr};
        if (dbg_ar_en) en_cnt <= en_cnt + 1;
    end

    dm_abstract_cmd_ctrl #(.READ_LAT(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .cmd_we_i(cmd_we_i), .cmd_i(cmd_i),
        .data0_we_i(data0_we_i), .data0_re_i(data0_re_i), .data0_i(data0_i), .data0_o(data0_o),
        .abscs_we_i(abscs_we_i), .cmderr_clr_i(cmderr_clr_i), .busy_o(busy_o), .cmderr_o(cmderr_o),
        .core_halted_i(core_halted_i), .dbg_ar_en(dbg_ar_en), .dbg_ar_wr(dbg_ar_wr),
        .dbg_ar_ad(dbg_ar_ad), .dbg_ar_do(dbg_ar_do), .dbg_ar_di(dbg_ar_di), .dbg_ar_err_i(dbg_ar_err_i)
`ifdef DM_AUTOEXEC_EN
        , .autoexec_we_i(autoexec_we_i), .autoexec_i(autoexec_i)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        abscs_we_i = 1'b1; cmderr_clr_i = 3'b111; cyc(); abscs_we_i = 1'b0; cmderr_clr_i = 3'd0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; cyc();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
        checks++; if (cmderr_o !== 3'd0) begin failures++; $display("FAIL reset_cmderr got=%0h exp=0", cmderr_o); end
        checks++; if (data0_o !== 32'd0) begin failures++; $display("FAIL reset_data0 got=%0h exp=0", data0_o); end
        checks++; if ({dbg_ar_en, dbg_ar_wr, dbg_ar_ad, dbg_ar_do} !== 50'd0) begin failures++; $display("FAIL reset_ar got=%0h exp=0", {dbg_ar_en, dbg_ar_wr, dbg_ar_ad, dbg_ar_do}); end
        reset_i = 1'b0; cyc();
    endtask

    task automatic test_write_dpc();
        data0_we_i = 1'b1; data0_i = 32'hDEADBEEF; cyc(); data0_we_i = 1'b0;
        checks++; if (data0_o !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data0 got=%0h exp=deadbeef", data0_o); end
        n0 = en_cnt;
        cmd_we_i = 1'b1; cmd_i = 32'h0023_07B1; cyc(); cmd_we_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL wr_busy_t1 got=%0h exp=1", busy_o); end
        checks++; if (dbg_ar_en !== 1'b1 || dbg_ar_wr !== 1'b1) begin failures++; $display("FAIL wr_en_t1 got=%0h%0h exp=11", dbg_ar_en, dbg_ar_wr); end
        checks++; if (dbg_ar_ad !== 16'h07B1) begin failures++; $display("FAIL wr_ad got=%0h exp=7b1", dbg_ar_ad); end
        checks++; if (dbg_ar_do !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_do got=%0h exp=deadbeef", dbg_ar_do); end
        cyc();
        checks++; if (busy_o !== 1'b1 || dbg_ar_en !== 1'b0) begin failures++; $display("FAIL wr_t2 got busy=%0h en=%0h exp busy=1 en=0", busy_o, dbg_ar_en); end
        cyc();
        checks++; if (busy_o !== 1'b0 || cmderr_o !== 3'd0) begin failures++; $display("FAIL wr_t3 got busy=%0h err=%0h exp 0 0", busy_o, cmderr_o); end
        checks++; if (en_cnt - n0 !== 1) begin failures++; $display("FAIL wr_pulses got=%0d exp=1", en_cnt - n0); end
    endtask

    task automatic test_read();
        core_val = 32'h0000_1234;
        cmd_we_i = 1'b1; cmd_i = 32'h0022_1005; cyc(); cmd_we_i = 1'b0;
        checks++; if (dbg_ar_en !== 1'b1 || dbg_ar_wr !== 1'b0 || dbg_ar_ad !== 16'h1005) begin failures++; $display("FAIL rd_issue got en=%0h wr=%0h ad=%0h exp 1 0 1005", dbg_ar_en, dbg_ar_wr, dbg_ar_ad); end
        for (int i = 2; i <= 4; i++) begin
            cyc();
            checks++; if (busy_o !== 1'b1 || dbg_ar_en !== 1'b0) begin failures++; $display("FAIL rd_busy_t%0d got busy=%0h en=%0h exp 1 0", i, busy_o, dbg_ar_en); end
        end
        cyc();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rd_busy_t5 got=%0h exp=0", busy_o); end
        checks++; if (data0_o !== 32'h0000_1234) begin failures++; $display("FAIL rd_data0 got=%0h exp=1234", data0_o); end
    endtask

    task automatic test_running();
        core_halted_i = 1'b0; n0 = en_cnt;
        cmd_we_i = 1'b1; cmd_i = 32'h0022_1005; cyc(); cmd_we_i = 1'b0;
        checks++; if (cmderr_o !== 3'd4 || busy_o !== 1'b0) begin failures++; $display("FAIL run_haltresume got err=%0h busy=%0h exp 4 0", cmderr_o, busy_o); end
        cyc();
        checks++; if (en_cnt != n0) begin failures++; $display("FAIL run_no_en got=%0d exp=0", en_cnt - n0); end
        clear_err();
        checks++; if (cmderr_o !== 3'd0) begin failures++; $display("FAIL run_w1c got=%0h exp=0", cmderr_o); end
        cmd_we_i = 1'b1; cmd_i = 32'h0032_1005; cyc(); cmd_we_i = 1'b0;
        checks++; if (cmderr_o !== 3'd2) begin failures++; $display("FAIL run_aarsize got=%0h exp=2", cmderr_o); end
        core_halted_i = 1'b1;
        abscs_we_i = 1'b1; cmderr_clr_i = 3'b111; cmd_we_i = 1'b1; cmd_i = 32'h0023_07B1; cyc();
        abscs_we_i = 1'b0; cmderr_clr_i = 3'd0; cmd_we_i = 1'b0;
        checks++; if (cmderr_o !== 3'd0 || busy_o !== 1'b0) begin failures++; $display("FAIL clr_and_cmd got err=%0h busy=%0h exp 0 0", cmderr_o, busy_o); end
    endtask

    task automatic test_busy_err();
        core_val = 32'hCAFE_0001;
        cmd_we_i = 1'b1; cmd_i = 32'h0022_1005; cyc(); cmd_we_i = 1'b0;
        cyc();
        data0_we_i = 1'b1; data0_i = 32'h5555_5555; cyc(); data0_we_i = 1'b0;
        checks++; if (cmderr_o !== 3'd1) begin failures++; $display("FAIL busy_err got=%0h exp=1", cmderr_o); end
        cyc(); cyc();
        checks++; if (busy_o !== 1'b0 || data0_o !== 32'hCAFE_0001) begin failures++; $display("FAIL busy_data0 got busy=%0h d0=%0h exp 0 cafe0001", busy_o, data0_o); end
        n0 = en_cnt;
        cmd_we_i = 1'b1; cmd_i = 32'h0023_07B1; cyc(); cmd_we_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || cmderr_o !== 3'd1) begin failures++; $display("FAIL busy_ignore got busy=%0h err=%0h exp 0 1", busy_o, cmderr_o); end
        cyc();
        checks++; if (en_cnt != n0) begin failures++; $display("FAIL busy_ignore_en got=%0d exp=0", en_cnt - n0); end
        abscs_we_i = 1'b1; cmderr_clr_i = 3'b001; cyc(); abscs_we_i = 1'b0; cmderr_clr_i = 3'd0;
        checks++; if (cmderr_o !== 3'd0) begin failures++; $display("FAIL busy_w1c got=%0h exp=0", cmderr_o); end
    endtask

    task automatic test_except();
        err_inject = 1'b1;
        cmd_we_i = 1'b1; cmd_i = 32'h0023_07B0; cyc(); cmd_we_i = 1'b0;
        cyc(); err_inject = 1'b0;
        checks++; if (cmderr_o !== 3'd3 || busy_o !== 1'b1) begin failures++; $display("FAIL except got err=%0h busy=%0h exp 3 1", cmderr_o, busy_o); end
        cyc();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL except_done got=%0h exp=0", busy_o); end
        clear_err();
    endtask

    task automatic test_halt_drop();
        data0_we_i = 1'b1; data0_i = 32'h1111_2222; cyc(); data0_we_i = 1'b0;
        cmd_we_i = 1'b1; cmd_i = 32'h0022_1005; cyc(); cmd_we_i = 1'b0;
        cyc();
        core_halted_i = 1'b0; cyc();
        checks++; if (cmderr_o !== 3'd4 || busy_o !== 1'b1) begin failures++; $display("FAIL drop_err got err=%0h busy=%0h exp 4 1", cmderr_o, busy_o); end
        cyc(); core_halted_i = 1'b1;
        checks++; if (busy_o !== 1'b0 || data0_o !== 32'h1111_2222) begin failures++; $display("FAIL drop_data0 got busy=%0h d0=%0h exp 0 11112222", busy_o, data0_o); end
        cyc(); clear_err();
    endtask

    task automatic test_reset_wait();
        cmd_we_i = 1'b1; cmd_i = 32'h0022_1005; cyc(); cmd_we_i = 1'b0;
        cyc();
        reset_i = 1'b1; cyc(); reset_i = 1'b0;
        checks++; if ({busy_o, cmderr_o, data0_o} !== 36'd0) begin failures++; $display("FAIL rstwait_regs got=%0h exp=0", {busy_o, cmderr_o, data0_o}); end
        checks++; if ({dbg_ar_en, dbg_ar_wr, dbg_ar_ad, dbg_ar_do} !== 50'd0) begin failures++; $display("FAIL rstwait_ar got=%0h exp=0", {dbg_ar_en, dbg_ar_wr, dbg_ar_ad, dbg_ar_do}); end
        cyc(); cyc();
    endtask

    task automatic test_back_to_back();
        n0 = en_cnt;
        cmd_we_i = 1'b1; cmd_i = 32'h0020_0000; cyc(); cmd_we_i = 1'b0;
        checks++; if (busy_o !== 1'b1 || dbg_ar_en !== 1'b0) begin failures++; $display("FAIL notx_t1 got busy=%0h en=%0h exp 1 0", busy_o, dbg_ar_en); end
        cyc();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL notx_t2 got=%0h exp=0", busy_o); end
        data0_we_i = 1'b1; data0_i = 32'h0BAD_F00D; cyc(); data0_we_i = 1'b0;
        cmd_we_i = 1'b1; cmd_i = 32'h0023_07B1; cyc(); cmd_we_i = 1'b0;
        checks++; if (dbg_ar_en !== 1'b1 || dbg_ar_do !== 32'h0BAD_F00D) begin failures++; $display("FAIL b2b_issue got en=%0h do=%0h exp 1 badf00d", dbg_ar_en, dbg_ar_do); end
        cyc(); cyc();
        checks++; if (en_cnt - n0 !== 1 || cmderr_o !== 3'd0) begin failures++; $display("FAIL b2b_end got pulses=%0d err=%0h exp 1 0", en_cnt - n0, cmderr_o); end
    endtask

`ifdef DM_AUTOEXEC_EN
    task automatic test_autoexec();
        autoexec_we_i = 1'b1; autoexec_i = 1'b1; cyc(); autoexec_we_i = 1'b0;
        n0 = en_cnt;
        for (int k = 1; k <= 2; k++) begin
            data0_we_i = 1'b1; data0_i = 32'hA5A5_0000 + k; cyc(); data0_we_i = 1'b0;
            checks++; if (dbg_ar_en !== 1'b1 || dbg_ar_do !== 32'hA5A5_0000 + k) begin failures++; $display("FAIL autoexec_%0d got en=%0h do=%0h exp 1 %0h", k, dbg_ar_en, dbg_ar_do, 32'hA5A5_0000 + k); end
            cyc(); cyc();
        end
        checks++; if (en_cnt - n0 !== 2) begin failures++; $display("FAIL autoexec_pulses got=%0d exp=2", en_cnt - n0); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_dpc();
        test_read();
        test_running();
        test_busy_err();
        test_except();
        test_halt_drop();
        test_reset_wait();
        test_back_to_back();
`ifdef DM_AUTOEXEC_EN
        test_autoexec();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
